// File: rtl/mem_stage.sv
// Memory-access pipeline stage: performs byte/half/word loads and stores over a
// req/ack data port and registers the MEM/WB write-back bundle.
module mem_stage #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [31:0] i_ALUOutput,
  input  logic [31:0] i_rd2,
  input  logic [2:0]  i_func3,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic        i_MemToReg,
  input  logic        i_RegWrite,
  input  logic [4:0]  i_write_reg,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_wb_reg,
  output logic        o_wb_RegWrite,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  typedef enum logic {IDLE, ACCESS} state_t;
  localparam int CW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          req_q, we_q;
  logic [31:0]   addr_q, wdata_q, alu_q;
  logic [3:0]    be_q;
  logic [2:0]    func3_q;
  logic [1:0]    lane_q;
  logic          memtoreg_q, regwrite_q;
  logic [4:0]    reg_q;
  logic          wb_valid_q, wb_rw_q, mis_q, berr_q;
  logic [31:0]   wb_data_q;
  logic [4:0]    wb_reg_q;

  logic mem_op_d, misaligned_d, start_d, timeout_d, regwrite_d;

  function automatic logic [3:0] be_of(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] r;
    case (f3[1:0])
      2'b00:   r = 4'b0001 << a;
      2'b01:   r = 4'b0011 << a;
      default: r = 4'hF;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_of(input logic [2:0] f3, input logic [1:0] a,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd4:    r = {24'd0, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd5:    r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic r;
    case (f3[1:0])
      2'b00:   r = 1'b0;
      2'b01:   r = a[0];
      default: r = (a != 2'd0);
    endcase
    return r;
  endfunction

  always_comb begin
    mem_op_d     = i_MemRead | i_MemWrite;
    misaligned_d = is_misaligned(i_func3, i_ALUOutput[1:0]);
    start_d      = (state_q == IDLE) && i_valid && mem_op_d && !misaligned_d;
    timeout_d    = (state_q == ACCESS) && !i_dmem_ack && (ACK_TIMEOUT != 0) &&
                   (({{(32-CW){1'b0}}, cnt_q} + 32'd1) == 32'(ACK_TIMEOUT));
    regwrite_d   = i_RegWrite & ~i_MemWrite & (i_write_reg != 5'd0);
    // Stall drops in the ack/timeout cycle so upstream advances on the same edge.
    o_stall      = start_d || ((state_q == ACCESS) && !i_dmem_ack && !timeout_d);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;   cnt_q <= '0;
      req_q <= 1'b0;     we_q <= 1'b0;     addr_q <= '0;    be_q <= '0;
      wdata_q <= '0;     alu_q <= '0;      func3_q <= '0;   lane_q <= '0;
      memtoreg_q <= 1'b0; regwrite_q <= 1'b0; reg_q <= '0;
      wb_valid_q <= 1'b0; wb_data_q <= '0; wb_reg_q <= '0;
      wb_rw_q <= 1'b0;   mis_q <= 1'b0;    berr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          wb_valid_q <= 1'b0;
          mis_q      <= 1'b0;
          berr_q     <= 1'b0;
          if (start_d) begin
            state_q    <= ACCESS;
            cnt_q      <= '0;
            req_q      <= 1'b1;
            we_q       <= i_MemWrite;
            addr_q     <= {i_ALUOutput[31:2], 2'b00};
            be_q       <= be_of(i_func3, i_ALUOutput[1:0]);
            wdata_q    <= wdata_of(i_func3, i_rd2);
            alu_q      <= i_ALUOutput;
            func3_q    <= i_func3;
            lane_q     <= i_ALUOutput[1:0];
            memtoreg_q <= i_MemToReg;
            regwrite_q <= regwrite_d;
            reg_q      <= i_write_reg;
          end else if (i_valid) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= i_ALUOutput;
            wb_reg_q   <= i_write_reg;
            wb_rw_q    <= regwrite_d & ~mem_op_d;
            mis_q      <= mem_op_d;
          end
        end
        ACCESS: begin
          if (i_dmem_ack || timeout_d) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_reg_q   <= reg_q;
            wb_data_q  <= (i_dmem_ack && memtoreg_q) ?
                          load_of(func3_q, lane_q, i_dmem_rdata) : alu_q;
            wb_rw_q    <= i_dmem_ack & regwrite_q;
            berr_q     <= ~i_dmem_ack;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_dmem_req    = req_q;
  assign o_dmem_we     = we_q;
  assign o_dmem_addr   = addr_q;
  assign o_dmem_be     = be_q;
  assign o_dmem_wdata  = wdata_q;
  assign o_wb_valid    = wb_valid_q;
  assign o_wb_data     = wb_data_q;
  assign o_wb_reg      = wb_reg_q;
  assign o_wb_RegWrite = wb_rw_q;
  assign o_misaligned  = mis_q;
  assign o_bus_err     = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected WB bundles are queued at issue and
// compared by a monitor whenever o_wb_valid is seen.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] alu, rd2, rdata;
  logic [2:0]  f3;
  logic        mr, mw, m2r, rw, ack;
  logic [4:0]  wreg;
  logic        req, we, stall, wb_valid, wb_rw, mis, berr;
  logic [31:0] addr, wdata, wb_data;
  logic [3:0]  be;
  logic [4:0]  wb_reg;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        berr;
  } exp_t;
  exp_t sb[$];

  mem_stage #(.ACK_TIMEOUT(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_ALUOutput(alu), .i_rd2(rd2),
    .i_func3(f3), .i_MemRead(mr), .i_MemWrite(mw), .i_MemToReg(m2r),
    .i_RegWrite(rw), .i_write_reg(wreg), .o_dmem_req(req), .o_dmem_we(we),
    .o_dmem_addr(addr), .o_dmem_be(be), .o_dmem_wdata(wdata), .i_dmem_ack(ack),
    .i_dmem_rdata(rdata), .o_stall(stall), .o_wb_valid(wb_valid),
    .o_wb_data(wb_data), .o_wb_reg(wb_reg), .o_wb_RegWrite(wb_rw),
    .o_misaligned(mis), .o_bus_err(berr)
  );

  always #5 clk = ~clk;

  // Monitor: every WB pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      exp_t e;
      exp_t got;
      got = '{data: wb_data, rd: wb_reg, rw: wb_rw, mis: mis, berr: berr};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got %h, expected no write-back", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL wb_bundle: got data=%h rd=%0d rw=%b mis=%b berr=%b, expected data=%h rd=%0d rw=%b mis=%b berr=%b",
                   got.data, got.rd, got.rw, got.mis, got.berr, e.data, e.rd, e.rw, e.mis, e.berr);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] fn,
                       input logic r, input logic w, input logic m, input logic regw,
                       input logic [4:0] rd);
    valid = 1'b1; alu = a; rd2 = d; f3 = fn; mr = r; mw = w; m2r = m; rw = regw; wreg = rd;
  endtask

  task automatic idle();
    valid = 1'b0; mr = 1'b0; mw = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); ack = 1'b0; alu = '0; rd2 = '0; f3 = '0; m2r = 0; rw = 0;
    wreg = '0; rdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req, we, addr, be, wdata, stall, wb_valid, wb_data, wb_reg, wb_rw, mis, berr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b stall=%b wb_valid=%b wb_data=%h, expected all zero",
               req, stall, wb_valid, wb_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu();
    drive(32'h1234, 32'h0, 3'd2, 0, 0, 0, 1, 5'd5);
    sb.push_back('{data: 32'h1234, rd: 5'd5, rw: 1'b1, mis: 1'b0, berr: 1'b0});
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %b, expected 0", stall); end
    @(negedge clk); idle();
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_pulse: wb_valid=%b, expected 0", wb_valid); end
  endtask

  task automatic test_load(input logic unsgn);
    int stalls;
    logic [31:0] expv;
    expv = unsgn ? 32'h0000_0080 : 32'hFFFF_FF80;
    rdata = 32'h80FF_0000;
    drive(32'h103, 32'h0, unsgn ? 3'd4 : 3'd0, 1, 0, 1, 1, 5'd7);
    sb.push_back('{data: expv, rd: 5'd7, rw: 1'b1, mis: 1'b0, berr: 1'b0});
    #1;
    stalls = (stall === 1'b1) ? 1 : 0;
    @(negedge clk); idle();
    checks++;
    if (req !== 1'b1 || addr !== 32'h100 || we !== 1'b0 || be !== 4'b1000) begin
      errors++;
      $display("FAIL load_req: req=%b addr=%h we=%b be=%b, expected 1 00000100 0 1000", req, addr, we, be);
    end
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      ack = (k == 4);
      #1;
      if (stall === 1'b1) stalls++;
      checks++;
      if (req !== 1'b1 || addr !== 32'h100) begin
        errors++;
        $display("FAIL load_hold: cycle %0d req=%b addr=%h, expected 1 00000100", k, req, addr);
      end
    end
    @(negedge clk); ack = 1'b0;
    checks++;
    if (stalls != 4) begin errors++; $display("FAIL load_stall_cycles: got %0d, expected 4", stalls); end
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL load_req_drop: req=%b, expected 0", req); end
    @(negedge clk);
  endtask

  task automatic test_store();
    drive(32'h202, 32'hABCD_1234, 3'd1, 0, 1, 0, 1, 5'd3);
    sb.push_back('{data: 32'h202, rd: 5'd3, rw: 1'b0, mis: 1'b0, berr: 1'b0});
    @(negedge clk); idle();
    checks++;
    if (req !== 1'b1 || we !== 1'b1 || be !== 4'b1100 || wdata !== 32'h1234_1234 || addr !== 32'h200) begin
      errors++;
      $display("FAIL sh_req: req=%b we=%b be=%b wdata=%h addr=%h, expected 1 1 1100 12341234 00000200",
               req, we, be, wdata, addr);
    end
    ack = 1'b1; #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL sh_stall_ack: got %b, expected 0", stall); end
    @(negedge clk); ack = 1'b0;
    checks++;
    if (wb_valid !== 1'b1) begin errors++; $display("FAIL sh_latency: wb_valid=%b, expected 1", wb_valid); end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    drive(32'h301, 32'h0, 3'd2, 1, 0, 1, 1, 5'd4);
    sb.push_back('{data: 32'h301, rd: 5'd4, rw: 1'b0, mis: 1'b1, berr: 1'b0});
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall: got %b, expected 0", stall); end
    @(negedge clk); idle();
    checks++;
    if (req !== 1'b0 || mis !== 1'b1) begin
      errors++; $display("FAIL mis_flag: req=%b mis=%b, expected 0 1", req, mis);
    end
    @(negedge clk);
    checks++;
    if (mis !== 1'b0) begin errors++; $display("FAIL mis_pulse: mis=%b, expected 0", mis); end
  endtask

  task automatic test_timeout();
    int cyc = 0;
    drive(32'h400, 32'h0, 3'd2, 1, 0, 1, 1, 5'd9);
    sb.push_back('{data: 32'h400, rd: 5'd9, rw: 1'b0, mis: 1'b0, berr: 1'b1});
    @(negedge clk); idle();
    while (req === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc != 16) begin errors++; $display("FAIL timeout_cycles: got %0d, expected 16", cyc); end
    checks++;
    if (berr !== 1'b1 || req !== 1'b0) begin
      errors++; $display("FAIL timeout_flag: berr=%b req=%b, expected 1 0", berr, req);
    end
    @(negedge clk);
    checks++;
    if (berr !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: berr=%b stall=%b, expected 0 0", berr, stall);
    end
  endtask

  task automatic test_back_to_back();
    drive(32'hCAFE, 32'h0, 3'd2, 0, 0, 0, 1, 5'd1);
    sb.push_back('{data: 32'hCAFE, rd: 5'd1, rw: 1'b1, mis: 1'b0, berr: 1'b0});
    @(negedge clk);
    drive(32'hBEEF, 32'h0, 3'd2, 0, 0, 0, 1, 5'd0);
    sb.push_back('{data: 32'hBEEF, rd: 5'd0, rw: 1'b0, mis: 1'b0, berr: 1'b0});
    @(negedge clk);
    rdata = 32'h8001_1234;
    drive(32'h2, 32'h0, 3'd5, 1, 0, 1, 1, 5'd12);
    sb.push_back('{data: 32'h0000_8001, rd: 5'd12, rw: 1'b1, mis: 1'b0, berr: 1'b0});
    @(negedge clk); idle(); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    @(negedge clk);
    drive(32'h2, 32'h0, 3'd1, 1, 0, 1, 1, 5'd13);
    sb.push_back('{data: 32'hFFFF_8001, rd: 5'd13, rw: 1'b1, mis: 1'b0, berr: 1'b0});
    @(negedge clk); idle(); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive(32'h500, 32'h0, 3'd2, 1, 0, 1, 1, 5'd6);
    @(negedge clk); idle();
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL rst_mid_req: got %b, expected 1", req); end
    rst = 1'b1; #1;
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL rst_mid_drop: req=%b, expected 0", req); end
    @(negedge clk); rst = 1'b0; ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    checks++;
    if ({req, wb_valid, wb_data, wb_rw, mis, berr, stall} !== '0) begin
      errors++;
      $display("FAIL rst_mid_after: req=%b wb_valid=%b wb_data=%h stall=%b, expected all zero",
               req, wb_valid, wb_data, stall);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load(1'b0);
    test_load(1'b1);
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
